if_id_fetch_queue: RTL and testbench

- IF/ID decoupling stage directly downstream of the instruction fetch unit (PC register, PC adder, instruction memory).
- Captures each fetched instruction and its PC+4 into a small in-order FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Backpressure from decode deasserts InReady so fetch holds the PC.
- Flush (taken branch/jump) discards every queued instruction.

---
 rtl/if_id_fetch_queue.sv | 102 ++++++++++
 tb/tb_if_id_fetch_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_fetch_queue
// Purpose  : IF/ID decoupling FIFO. Captures {instruction, PC+4} from fetch
//            and presents the oldest entry to decode with valid/ready.
//            Flush discards all queued entries and any same-cycle push.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       InValid,
  input  logic [WIDTH-1:0]           InInstruction,
  input  logic [WIDTH-1:0]           InPCPlus4,
  output logic                       InReady,
  output logic                       OutValid,
  output logic [WIDTH-1:0]           OutInstruction,
  output logic [WIDTH-1:0]           OutPCPlus4,
  input  logic                       OutReady,
  input  logic                       Flush,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] instr_q [DEPTH];
  logic [WIDTH-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push_w;
  logic pop_w;
  logic not_empty_w;

  // Handshake qualification; ready depends on occupancy only, so a full
  // queue never accepts a push even when decode pops in the same cycle.
  always_comb begin
    not_empty_w = (count_q != '0);
    InReady     = (count_q < CNT_W'(DEPTH));
    push_w      = InValid & InReady & ~Flush;
    pop_w       = not_empty_w & OutReady & ~Flush;
  end

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_w)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_w && !pop_w)      count_d = count_q + CNT_W'(1);
      else if (pop_w && !push_w) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written at the write pointer on an accepted push.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push_w) begin
      instr_q[wr_ptr_q] <= InInstruction;
      pc_q[wr_ptr_q]    <= InPCPlus4;
    end
  end

  // Head presentation; gated to zero (NOP) whenever the queue is empty so
  // stale storage after a flush is never visible.
  always_comb begin
    OutValid       = not_empty_w;
    OutInstruction = not_empty_w ? instr_q[rd_ptr_q] : '0;
    OutPCPlus4     = not_empty_w ? pc_q[rd_ptr_q]    : '0;
    Count          = count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_fetch_queue
// Purpose  : Scoreboard bench for if_id_fetch_queue (DEPTH=2, WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_fetch_queue;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        InValid = 1'b0;
  logic [31:0] InInstruction = '0;
  logic [31:0] InPCPlus4 = '0;
  logic        InReady;
  logic        OutValid;
  logic [31:0] OutInstruction;
  logic [31:0] OutPCPlus4;
  logic        OutReady = 1'b0;
  logic        Flush = 1'b0;
  logic [1:0]  Count;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q [$];

  if_id_fetch_queue #(.DEPTH(2), .WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .InValid(InValid), .InInstruction(InInstruction), .InPCPlus4(InPCPlus4),
    .InReady(InReady),
    .OutValid(OutValid), .OutInstruction(OutInstruction), .OutPCPlus4(OutPCPlus4),
    .OutReady(OutReady), .Flush(Flush), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] cnt, input logic vld, input logic rdy);
    chk({tag, ".Count"},    32'(Count),    32'(cnt));
    chk({tag, ".OutValid"}, 32'(OutValid), 32'(vld));
    chk({tag, ".InReady"},  32'(InReady),  32'(rdy));
  endtask

  // Offer an entry for one cycle; expected is queued only if it should land.
  task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic accept, input logic rdy);
    InValid = 1'b1; InInstruction = ins; InPCPlus4 = pc; OutReady = rdy;
    if (accept) exp_q.push_back({ins, pc});
    step();
    InValid = 1'b0;
  endtask

  // Monitor: every consumed head must match the oldest expected entry;
  // an idle head must read as a zero NOP.
  initial begin
    forever begin
      @(negedge Clk);
      if (Rst) begin
        if (OutValid && OutReady && !Flush) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mon.unexpected: got %h/%h expected no output", OutInstruction, OutPCPlus4);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("mon.instr", OutInstruction, e[63:32]);
            chk("mon.pc",    OutPCPlus4,     e[31:0]);
          end
        end else if (!OutValid) begin
          chk("mon.idle_instr", OutInstruction, 32'h0);
          chk("mon.idle_pc",    OutPCPlus4,     32'h0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    #1;
    chk_state("rst", 2'd0, 1'b0, 1'b1);
    chk("rst.instr", OutInstruction, 32'h0);
    step(); step();
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("idle", 2'd0, 1'b0, 1'b1);
      chk("idle.instr", OutInstruction, 32'h0);
    end

    // Single push / pop
    offer(32'h20080005, 32'h4, 1'b1, 1'b0);
    chk_state("single", 2'd1, 1'b1, 1'b1);
    chk("single.instr", OutInstruction, 32'h20080005);
    chk("single.pc",    OutPCPlus4,     32'h4);
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    chk_state("single_pop", 2'd0, 1'b0, 1'b1);

    // Fill and backpressure
    offer(32'h11111111, 32'h8,  1'b1, 1'b0);
    offer(32'h22222222, 32'hC,  1'b1, 1'b0);
    chk_state("full", 2'd2, 1'b1, 1'b0);
    offer(32'h33333333, 32'h10, 1'b0, 1'b0);
    chk_state("full_drop", 2'd2, 1'b1, 1'b0);
    chk("full_head", OutInstruction, 32'h11111111);
    OutReady = 1'b1;
    step(); step();
    chk_state("drained", 2'd0, 1'b0, 1'b1);

    // Pop on empty: no underflow
    step();
    OutReady = 1'b0;
    chk_state("empty_pop", 2'd0, 1'b0, 1'b1);

    // Simultaneous push/pop at Count=1 across pointer wrap
    offer(32'hA0000000, 32'd4, 1'b1, 1'b0);
    for (int k = 1; k < 6; k++) begin
      offer(32'hA0000000 + 32'(k), 32'(4 * (k + 1)), 1'b1, 1'b1);
      chk("simul.count", 32'(Count), 32'd1);
      chk("simul.head",  OutInstruction, 32'hA0000000 + 32'(k));
    end
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    chk_state("simul_end", 2'd0, 1'b0, 1'b1);
    chk("simul.sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush with concurrent push and pop
    offer(32'hB1B1B1B1, 32'h40, 1'b1, 1'b0);
    offer(32'hB2B2B2B2, 32'h44, 1'b1, 1'b0);
    chk_state("pre_flush", 2'd2, 1'b1, 1'b0);
    Flush = 1'b1; InValid = 1'b1; InInstruction = 32'hDDDDDDDD; InPCPlus4 = 32'h48; OutReady = 1'b1;
    step();
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    exp_q.delete();
    chk_state("flush", 2'd0, 1'b0, 1'b1);
    chk("flush.instr", OutInstruction, 32'h0);
    chk("flush.pc",    OutPCPlus4,     32'h0);
    OutReady = 1'b1;
    step(); step();
    OutReady = 1'b0;
    chk_state("post_flush", 2'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream
    offer(32'hC1C1C1C1, 32'h80, 1'b1, 1'b0);
    offer(32'hC2C2C2C2, 32'h84, 1'b1, 1'b0);
    chk_state("pre_arst", 2'd2, 1'b1, 1'b0);
    #2;
    exp_q.delete();
    Rst = 1'b0;
    #1;
    chk_state("arst", 2'd0, 1'b0, 1'b1);
    chk("arst.instr", OutInstruction, 32'h0);
    step();
    Rst = 1'b1;
    InValid = 1'b1; InInstruction = 32'hE0E0E0E0; InPCPlus4 = 32'h100;
    exp_q.push_back({32'hE0E0E0E0, 32'h100});
    #1;
    chk("post_arst.pre", 32'(OutValid), 32'd0);
    step();
    InValid = 1'b0;
    chk_state("post_arst", 2'd1, 1'b1, 1'b1);
    chk("post_arst.instr", OutInstruction, 32'hE0E0E0E0);
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    chk_state("final", 2'd0, 1'b0, 1'b1);
    chk("final.sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
